branch_cmp_seq: RTL and testbench

- Parametrised, iterative successor to the single-cycle branch comparator.
- Compares rs1/rs2 one CHUNK-bit slice per cycle, starting at the MSB slice, in signed or unsigned mode.
- Produces br_eq, br_lt and a funct3-decoded br_taken, with valid/ready handshakes on both sides.
- Intended for narrow-datapath or low-area cores where a full-width single-cycle compare is too costly.

---
 rtl/brcmp_pkg.sv | 19 +
 rtl/branch_cmp_seq_if.sv | 26 ++
 rtl/brcmp_slice.sv | 23 ++
 rtl/branch_cmp_seq.sv | 117 +++++++++++
 tb/tb_branch_cmp_seq.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/brcmp_pkg.sv
// rtl/brcmp_pkg.sv - shared types and funct3 decode for the iterative branch comparator
package brcmp_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} brcmp_state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct3 = 01x is not a branch encoding and never takes
  function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
    if (f3[2:1] == 2'b01) return 1'b0;
    return (f3[2] ? lt : eq) ^ f3[0];
  endfunction

endpackage

// File: rtl/branch_cmp_seq_if.sv
// rtl/branch_cmp_seq_if.sv - request/result handshake bundle for branch_cmp_seq
interface branch_cmp_seq_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic             br_un;
  logic [2:0]       funct3;
  logic             out_valid;
  logic             out_ready;
  logic             br_eq;
  logic             br_lt;
  logic             br_taken;

  modport master (
    output in_valid, rs1_data, rs2_data, br_un, funct3, out_ready,
    input  in_ready, out_valid, br_eq, br_lt, br_taken
  );

  modport slave (
    input  in_valid, rs1_data, rs2_data, br_un, funct3, out_ready,
    output in_ready, out_valid, br_eq, br_lt, br_taken
  );

endinterface

// File: rtl/brcmp_slice.sv
// rtl/brcmp_slice.sv - one CHUNK-bit compare; signed_top flips the sign bit so the
// unsigned compare orders two's complement values correctly
module brcmp_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             signed_top,
  output logic             eq,
  output logic             lt
);

  logic [CHUNK-1:0] flip;
  logic [CHUNK-1:0] a_m;
  logic [CHUNK-1:0] b_m;

  assign flip = CHUNK'(signed_top) << (CHUNK - 1);
  assign a_m  = a ^ flip;
  assign b_m  = b ^ flip;
  assign eq   = (a == b);
  assign lt   = (a_m < b_m);

endmodule

// File: rtl/branch_cmp_seq.sv
// rtl/branch_cmp_seq.sv - iterative MSB-first branch comparator, one slice per cycle
// BRCMP_EARLY_EXIT_EN: leave BUSY on the first differing slice instead of visiting all
module branch_cmp_seq
  import brcmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_cmp_seq_if.slave    bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NCHUNK - 1);

  brcmp_state_t     state;
  logic [WIDTH-1:0] rs1_q;
  logic [WIDTH-1:0] rs2_q;
  logic             un_q;
  logic [2:0]       f3_q;
  logic [IDXW-1:0]  idx;
  logic             decided;
  logic             lt_q;
  logic             out_valid_q;
  logic             br_eq_q;
  logic             br_lt_q;
  logic             br_taken_q;

  logic [CHUNK-1:0] sl_a;
  logic [CHUNK-1:0] sl_b;
  logic             sl_eq;
  logic             sl_lt;
  logic             hit;
  logic             fin_eq;
  logic             fin_lt;
  logic             finish;

  assign sl_a = rs1_q[int'(idx)*CHUNK +: CHUNK];
  assign sl_b = rs2_q[int'(idx)*CHUNK +: CHUNK];

  brcmp_slice #(.CHUNK(CHUNK)) u_slice (
    .a          (sl_a),
    .b          (sl_b),
    .signed_top (!un_q && (idx == TOP_IDX)),
    .eq         (sl_eq),
    .lt         (sl_lt)
  );

  // The first differing slice (from the MSB) owns the result; later slices cannot override it
  always_comb begin
    hit    = !decided && !sl_eq;
    fin_lt = hit ? sl_lt : lt_q;
    fin_eq = !(decided || hit);
`ifdef BRCMP_EARLY_EXIT_EN
    finish = hit || (idx == '0);
`else
    finish = (idx == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      br_eq_q     <= 1'b0;
      br_lt_q     <= 1'b0;
      br_taken_q  <= 1'b0;
      idx         <= TOP_IDX;
      decided     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rs1_q   <= bus.rs1_data;
            rs2_q   <= bus.rs2_data;
            un_q    <= bus.br_un;
            f3_q    <= bus.funct3;
            idx     <= TOP_IDX;
            decided <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (hit) begin
            decided <= 1'b1;
            lt_q    <= sl_lt;
          end
          if (finish) begin
            br_eq_q     <= fin_eq;
            br_lt_q     <= fin_lt;
            br_taken_q  <= branch_taken(f3_q, fin_eq, fin_lt);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.br_eq     = br_eq_q;
  assign bus.br_lt     = br_lt_q;
  assign bus.br_taken  = br_taken_q;

endmodule

// File: tb/tb_branch_cmp_seq.sv
// tb/tb_branch_cmp_seq.sv - directed bench driving a CHUNK=8 and a CHUNK=WIDTH comparator in lockstep
module tb_branch_cmp_seq;
  import brcmp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        br_un = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [2:0]  f3 = '0;

  always #5 clk = ~clk;

  branch_cmp_seq_if #(.WIDTH(32)) ifa ();
  branch_cmp_seq_if #(.WIDTH(32)) ifb ();

  assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
  assign ifa.rs1_data = rs1;       assign ifb.rs1_data = rs1;
  assign ifa.rs2_data = rs2;       assign ifb.rs2_data = rs2;
  assign ifa.br_un    = br_un;     assign ifb.br_un    = br_un;
  assign ifa.funct3   = f3;        assign ifb.funct3   = f3;
  assign ifa.out_ready = rdy;      assign ifb.out_ready = rdy;

  branch_cmp_seq #(.WIDTH(32), .CHUNK(8))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  branch_cmp_seq #(.WIDTH(32), .CHUNK(32)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int   checks = 0;
  int   errors = 0;
  logic exp_eq, exp_lt, exp_tk;
  logic expect_out = 1'b0;
  int   exp_lat_a, exp_lat_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic model_eq(input logic [31:0] a, input logic [31:0] b);
    return a == b;
  endfunction

  function automatic logic model_lt(input logic [31:0] a, input logic [31:0] b, input logic un);
    if (un) return a < b;
    return $signed(a) < $signed(b);
  endfunction

  function automatic logic model_tk(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b, input logic un);
    case (fn)
      F3_BEQ:           return model_eq(a, b);
      F3_BNE:           return !model_eq(a, b);
      F3_BLT, F3_BLTU:  return model_lt(a, b, un);
      F3_BGE, F3_BGEU:  return !model_lt(a, b, un);
      default:          return 1'b0;
    endcase
  endfunction

  // Slices examined: with early exit, up to and including the highest differing slice
  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input int chunk);
    int nch;
    nch = 32 / chunk;
`ifdef BRCMP_EARLY_EXIT_EN
    for (int s = nch - 1; s >= 0; s--) begin
      logic [63:0] m;
      logic [63:0] d;
      m = (64'd1 << chunk) - 64'd1;
      d = 64'(a ^ b) >> (s * chunk);
      if ((d & m) != 64'd0) return nch - s;
    end
`endif
    return nch;
  endfunction

  int cnt_a = 0;
  bit cnting_a = 0;
  always @(negedge clk) begin
    if (!rst_n) cnting_a = 0;
    else begin
      if (cnting_a) cnt_a++;
      if (ifa.out_valid) begin
        if (!expect_out) chk("a_spurious_out", 32'd1, 32'd0);
        else begin
          chk("a_br_eq", 32'(ifa.br_eq), 32'(exp_eq));
          chk("a_br_lt", 32'(ifa.br_lt), 32'(exp_lt));
          chk("a_br_taken", 32'(ifa.br_taken), 32'(exp_tk));
          chk("a_in_ready_busy", 32'(ifa.in_ready), 32'd0);
          if (cnting_a) begin
            chk("a_latency", 32'(cnt_a), 32'(exp_lat_a));
            cnting_a = 0;
          end
        end
      end
      if (ifa.in_valid && ifa.in_ready) begin
        cnting_a = 1;
        cnt_a = -1;
      end
    end
  end

  int cnt_b = 0;
  bit cnting_b = 0;
  always @(negedge clk) begin
    if (!rst_n) cnting_b = 0;
    else begin
      if (cnting_b) cnt_b++;
      if (ifb.out_valid) begin
        if (!expect_out) chk("b_spurious_out", 32'd1, 32'd0);
        else begin
          chk("b_br_eq", 32'(ifb.br_eq), 32'(exp_eq));
          chk("b_br_lt", 32'(ifb.br_lt), 32'(exp_lt));
          chk("b_br_taken", 32'(ifb.br_taken), 32'(exp_tk));
          chk("b_in_ready_busy", 32'(ifb.in_ready), 32'd0);
          if (cnting_b) begin
            chk("b_latency", 32'(cnt_b), 32'(exp_lat_b));
            cnting_b = 0;
          end
        end
      end
      if (ifb.in_valid && ifb.in_ready) begin
        cnting_b = 1;
        cnt_b = -1;
      end
    end
  end

  task automatic xact(input logic [31:0] a, input logic [31:0] b, input logic un,
                      input logic [2:0] fn, input int hold);
    int n;
    rs1 = a; rs2 = b; br_un = un; f3 = fn;
    exp_eq = model_eq(a, b);
    exp_lt = model_lt(a, b, un);
    exp_tk = model_tk(fn, a, b, un);
    exp_lat_a = model_lat(a, b, 8);
    exp_lat_b = model_lat(a, b, 32);
    expect_out = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    n = 0;
    while (!(ifa.out_valid && ifb.out_valid) && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 20) begin
      chk("result_timeout", 32'd0, 32'd1);
      expect_out = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      return;
    end
    repeat (hold) begin
      @(posedge clk); #2;
    end
    rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("a_out_valid_drop", 32'(ifa.out_valid), 32'd0);
    chk("b_out_valid_drop", 32'(ifb.out_valid), 32'd0);
    chk("a_in_ready_return", 32'(ifa.in_ready), 32'd1);
    chk("b_in_ready_return", 32'(ifb.in_ready), 32'd1);
    @(posedge clk); #2;
    rdy = 1'b0;
    expect_out = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    // Pin the model with hand-computed values
    chk("pin_signed_lt", 32'(model_lt(32'hFFFFFF9C, 32'h64, 1'b0)), 32'd1);
    chk("pin_unsigned_lt", 32'(model_lt(32'hFFFFFF9C, 32'h64, 1'b1)), 32'd0);
    chk("pin_beq_taken", 32'(model_tk(F3_BEQ, 32'h12345678, 32'h12345678, 1'b0)), 32'd1);
    chk("pin_bge_taken", 32'(model_tk(F3_BGE, 32'h10, 32'h11, 1'b0)), 32'd0);
    chk("pin_f3_010", 32'(model_tk(3'b010, 32'h80000000, 32'h7FFFFFFF, 1'b0)), 32'd0);
    chk("pin_low_slice_lat", 32'(model_lat(32'h10, 32'h11, 8)), 32'd4);
    chk("pin_equal_lat", 32'(model_lat(32'h12345678, 32'h12345678, 8)), 32'd4);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("a_rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("a_rst_br_eq", 32'(ifa.br_eq), 32'd0);
    chk("a_rst_br_lt", 32'(ifa.br_lt), 32'd0);
    chk("a_rst_br_taken", 32'(ifa.br_taken), 32'd0);
    chk("a_rst_in_ready", 32'(ifa.in_ready), 32'd1);
    chk("b_rst_out_valid", 32'(ifb.out_valid), 32'd0);
    chk("b_rst_in_ready", 32'(ifb.in_ready), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Reset mid-operation discards the request
    expect_out = 1'b0;
    rs1 = 32'd5; rs2 = 32'd5; br_un = 1'b0; f3 = F3_BEQ;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("a_midrst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("a_midrst_in_ready", 32'(ifa.in_ready), 32'd1);
    chk("b_midrst_out_valid", 32'(ifb.out_valid), 32'd0);
    chk("b_midrst_in_ready", 32'(ifb.in_ready), 32'd1);
    repeat (6) @(posedge clk);
    #2;

    xact(32'hFFFFFF9C, 32'h00000064, 1'b0, F3_BLT, 0);
    xact(32'hFFFFFF9C, 32'h00000064, 1'b1, F3_BLTU, 0);
    xact(32'h12345678, 32'h12345678, 1'b0, F3_BEQ, 0);
    xact(32'h12345678, 32'h12345678, 1'b0, F3_BNE, 0);
    xact(32'h00000010, 32'h00000011, 1'b0, F3_BGE, 0);
    xact(32'h00000010, 32'h00000011, 1'b1, F3_BGEU, 5);
    xact(32'h80000000, 32'h7FFFFFFF, 1'b0, F3_BLT, 0);
    xact(32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b010, 0);
    xact(32'h7FFFFFFF, 32'h80000000, 1'b1, 3'b011, 2);
    xact(32'h00FF0000, 32'h00FE0000, 1'b0, F3_BGE, 0);
    xact(32'hFFFFFFFF, 32'h00000000, 1'b1, F3_BLTU, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
